// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: drives one full-frame pass through the line-buffer
// convolver. Issues raster-order pixel reads, generates the convolver shift
// enable, tags convolver outputs that are complete windows with their result
// row/column/address, and provides the start/busy/done handshake.
//
// Handshake: start is sampled only in IDLE. busy is high while the frame is
// reading or draining. done pulses for one cycle after the last window_valid.
// stall only gates new reads (pix_rd). Reads already in flight always complete.
//
// Optional build macro CONV_STRIDE2_EN: emit only windows whose unstrided
// indices are both even, numbered at half resolution. Read and done timing
// are the same in both builds.
module conv_frame_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int IMAGE_SIZE     = 28,
  parameter int KERNEL_SIZE    = 5,
  parameter int CONV_LATENCY   = 1,
  parameter int ADDR_WIDTH     = 10,
  parameter int OUT_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stall,
  output logic                      busy,
  output logic                      done,
  output logic                      pix_rd,
  output logic [ADDR_WIDTH-1:0]     pix_addr,
  output logic                      shift_en,
  output logic                      window_valid,
  output logic [4:0]                out_row,
  output logic [4:0]                out_col,
  output logic [OUT_ADDR_WIDTH-1:0] out_addr
);

  localparam int CW = $clog2(IMAGE_SIZE);
`ifdef CONV_STRIDE2_EN
  localparam int OUT_SIZE = (IMAGE_SIZE - KERNEL_SIZE) / 2 + 1;
`else
  localparam int OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
`endif
  localparam logic [CW-1:0] LAST_IDX  = CW'(IMAGE_SIZE - 1);
  localparam logic [CW-1:0] FIRST_WIN = CW'(KERNEL_SIZE - 1);

  // Reject parameter sets the address counters or pipeline cannot represent.
  if (DATA_WIDTH < 1 || CONV_LATENCY < 1 ||
      (64'd1 << ADDR_WIDTH) < 64'(IMAGE_SIZE * IMAGE_SIZE)) begin : g_bad_params
    $error("conv_frame_sequencer: unsupported parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          rd_row;
  logic [CW-1:0]          rd_col;
  logic [CONV_LATENCY-1:0] vld_pipe;
  logic [CW-1:0]          row_pipe [CONV_LATENCY];
  logic [CW-1:0]          col_pipe [CONV_LATENCY];
  logic [CW-1:0]          tap_row, tap_col, win_row, win_col;
  logic                   win_hit;
  logic [4:0]             res_row, res_col;

  // Reads follow stall directly so a stalled cycle never issues a read.
  assign pix_rd   = (state == S_RUN) && !stall;
  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  // Memory read latency is one cycle, so the first pipeline stage is the shift enable.
  assign shift_en = vld_pipe[0];

  // Frame FSM and raster read counters (advance only on an issued read).
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rd_row   <= '0;
      rd_col   <= '0;
      pix_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            rd_row   <= '0;
            rd_col   <= '0;
            pix_addr <= '0;
          end
        end
        S_RUN: begin
          if (pix_rd) begin
            if (rd_col == LAST_IDX) begin
              rd_col <= '0;
              if (rd_row == LAST_IDX) begin
                rd_row   <= '0;
                pix_addr <= '0;
                state    <= S_DRAIN;
              end else begin
                rd_row   <= rd_row + CW'(1);
                pix_addr <= pix_addr + ADDR_WIDTH'(1);
              end
            end else begin
              rd_col   <= rd_col + CW'(1);
              pix_addr <= pix_addr + ADDR_WIDTH'(1);
            end
          end
        end
        // Leave once no read is in flight; the last window is on the output then.
        S_DRAIN: if (vld_pipe == '0) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Track each read's row/column until its convolver result appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < CONV_LATENCY; i++) begin
        row_pipe[i] <= '0;
        col_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= pix_rd;
      row_pipe[0] <= rd_row;
      col_pipe[0] <= rd_col;
      for (int i = 1; i < CONV_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        row_pipe[i] <= row_pipe[i-1];
        col_pipe[i] <= col_pipe[i-1];
      end
    end
  end

  // Decide whether the result leaving the pipeline next cycle is a full window.
  always_comb begin
    tap_row = row_pipe[CONV_LATENCY-1];
    tap_col = col_pipe[CONV_LATENCY-1];
    win_row = tap_row - FIRST_WIN;
    win_col = tap_col - FIRST_WIN;
    win_hit = vld_pipe[CONV_LATENCY-1] && (tap_row >= FIRST_WIN) && (tap_col >= FIRST_WIN);
`ifdef CONV_STRIDE2_EN
    win_hit = win_hit && !win_row[0] && !win_col[0];
    res_row = 5'(win_row >> 1);
    res_col = 5'(win_col >> 1);
`else
    res_row = 5'(win_row);
    res_col = 5'(win_col);
`endif
  end

  // Registered result tags; indices hold between valid windows.
  always_ff @(posedge clk) begin
    if (reset) begin
      window_valid <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
      out_addr     <= '0;
    end else begin
      window_valid <= win_hit;
      if (win_hit) begin
        out_row  <= res_row;
        out_col  <= res_col;
        out_addr <= OUT_ADDR_WIDTH'(int'(res_row) * OUT_SIZE + int'(res_col));
      end
    end
  end

endmodule
